branch_resolver: RTL and testbench

Sequencer that owns the program counter and resolves conditional branches (brzr/brnz/brpl/brmi) for the Mini SRC datapath. On a start request it requests Ra onto the bus and pulses `con_in` so the condition flip-flop captures the comparison. It then reads back the registered `con` flag and updates PC to PC + sext(C) when the branch is taken. It sits between the control unit (start/done handshake) and the condition flip-flop / bus datapath.

---
 rtl/branch_resolver_if.sv | 27 ++
 rtl/branch_resolver.sv | 75 +++++++
 tb/tb_branch_resolver.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/branch_resolver_if.sv
// Control/datapath signal bundle for the conditional-branch sequencer.
// The slave side is the resolver; the master side is the control unit plus the condition flip-flop.
interface branch_resolver_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                start;
  logic [31:0]         ir;
  logic                con;
  logic                pc_inc;
  logic                ra_out;
  logic                con_in;
  logic [PC_WIDTH-1:0] pc;
  logic                busy;
  logic                done;
  logic                taken;
  logic                bad_op;

  modport slave (
    input  start, ir, con, pc_inc,
    output ra_out, con_in, pc, busy, done, taken, bad_op
  );

  modport master (
    output start, ir, con, pc_inc,
    input  ra_out, con_in, pc, busy, done, taken, bad_op
  );
endinterface

// File: rtl/branch_resolver.sv
// Program-counter owner and conditional-branch sequencer for the Mini SRC datapath.
// Sequence: IDLE -> EVAL (Ra on bus, CON captures) -> DECIDE (apply offset) -> DONE.
module branch_resolver #(
  parameter logic [4:0]  BR_OPCODE = 5'b10010,
  parameter int unsigned PC_WIDTH  = 32
) (
  input logic         clk,
  input logic         clr_n,
  branch_resolver_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StEval, StDecide, StDone} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                taken_q, taken_d;
  logic                bad_op_q, bad_op_d;
  logic [PC_WIDTH-1:0] offset;
  logic                is_branch;

  // Condition select and register fields are consumed elsewhere in the datapath.
  logic unused_ir;
  assign unused_ir = ^bus.ir[26:19];

  assign offset    = {{(PC_WIDTH-19){bus.ir[18]}}, bus.ir[18:0]};
  assign is_branch = (bus.ir[31:27] == BR_OPCODE);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      taken_q  <= 1'b0;
      bad_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      taken_q  <= taken_d;
      bad_op_q <= bad_op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    taken_d  = taken_q;
    bad_op_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && is_branch) begin
          state_d = StEval;
        end else begin
          bad_op_d = bus.start;
          if (bus.pc_inc) pc_d = pc_q + PC_WIDTH'(1);
        end
      end
      StEval: state_d = StDecide;
      StDecide: begin
        taken_d = bus.con;
        if (bus.con) pc_d = pc_q + offset;
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.ra_out = (state_q == StEval);
  assign bus.con_in = (state_q == StEval);
  assign bus.done   = (state_q == StDone);
  assign bus.busy   = (state_q != StIdle);
  assign bus.pc     = pc_q;
  assign bus.taken  = taken_q;
  assign bus.bad_op = bad_op_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a behavioural condition flip-flop.
module tb_branch_resolver;
  localparam logic [4:0] BrOp = 5'b10010;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic con_ff;
  logic cond_next = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  branch_resolver_if #(.PC_WIDTH(32)) bif ();

  // Condition flip-flop: captures the bench-chosen outcome only when con_in is high.
  always @(posedge clk) begin
    if (!clr_n) con_ff <= 1'b0;
    else if (bif.con_in) con_ff <= cond_next;
  end
  assign bif.con = con_ff;

  branch_resolver #(.BR_OPCODE(BrOp), .PC_WIDTH(32)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bif)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    bif.start = 1'b0;
    bif.pc_inc = 1'b0;
    step();
    clr_n = 1'b1;
  endtask

  task automatic incr(input int n);
    bif.pc_inc = 1'b1;
    repeat (n) step();
    bif.pc_inc = 1'b0;
  endtask

  // mode 0: plain start; 1: pc_inc together with start; 2: start/pc_inc held throughout
  task automatic branch(input string tag, input logic [18:0] c, input logic cond,
                        input logic [31:0] pc0, input logic [31:0] pc1, input int mode);
    bif.ir = {BrOp, 4'd3, 2'b00, 2'b01, c};
    cond_next = cond;
    bif.start = 1'b1;
    bif.pc_inc = (mode != 0);
    step();
    if (mode != 2) begin
      bif.start = 1'b0;
      bif.pc_inc = 1'b0;
    end
    check({tag, ".eval_con_in"}, bif.con_in, 1'b1);
    check({tag, ".eval_ra_out"}, bif.ra_out, 1'b1);
    check({tag, ".eval_pc"}, bif.pc, pc0);
    check({tag, ".eval_done"}, bif.done, 1'b0);
    step();
    check({tag, ".decide_con_in"}, bif.con_in, 1'b0);
    check({tag, ".decide_con"}, bif.con, cond);
    check({tag, ".decide_busy"}, bif.busy, 1'b1);
    step();
    check({tag, ".done"}, bif.done, 1'b1);
    check({tag, ".pc"}, bif.pc, pc1);
    check({tag, ".taken"}, bif.taken, cond);
    step();
    bif.start = 1'b0;
    bif.pc_inc = 1'b0;
    check({tag, ".idle_done"}, bif.done, 1'b0);
    check({tag, ".idle_busy"}, bif.busy, 1'b0);
    check({tag, ".idle_pc"}, bif.pc, pc1);
    step();
    check({tag, ".settled_busy"}, bif.busy, 1'b0);
    check({tag, ".settled_pc"}, bif.pc, pc1);
  endtask

  initial begin
    bif.start = 1'b0;
    bif.pc_inc = 1'b0;
    bif.ir = '0;
    step();
    do_reset();
    check("rst.pc", bif.pc, 32'h0);
    check("rst.taken", bif.taken, 1'b0);
    check("rst.busy", bif.busy, 1'b0);
    check("rst.done", bif.done, 1'b0);
    check("rst.bad_op", bif.bad_op, 1'b0);
    check("rst.con_in", bif.con_in, 1'b0);

    incr(4);
    check("inc4.pc", bif.pc, 32'h4);

    do_reset();
    incr(16);
    check("inc16.pc", bif.pc, 32'h10);
    branch("brzr", 19'd5, 1'b1, 32'h10, 32'h15, 0);
    incr(11);
    check("inc11.pc", bif.pc, 32'h20);
    branch("brnz", 19'h40, 1'b0, 32'h20, 32'h20, 0);
    branch("back16", 19'h7FFF0, 1'b1, 32'h20, 32'h10, 0);
    branch("neg1", 19'h7FFFF, 1'b1, 32'h10, 32'h0F, 0);

    do_reset();
    branch("neg2", 19'h7FFFE, 1'b1, 32'h0, 32'hFFFF_FFFE, 0);
    branch("wrap", 19'd3, 1'b1, 32'hFFFF_FFFE, 32'h1, 0);
    branch("hold", 19'd2, 1'b1, 32'h1, 32'h3, 2);

    bif.ir = {5'b00011, 27'd7};
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    check("badop.pulse", bif.bad_op, 1'b1);
    check("badop.busy", bif.busy, 1'b0);
    check("badop.pc", bif.pc, 32'h3);
    step();
    check("badop.clear", bif.bad_op, 1'b0);
    bif.start = 1'b1;
    bif.pc_inc = 1'b1;
    step();
    bif.start = 1'b0;
    bif.pc_inc = 1'b0;
    check("badop_inc.pulse", bif.bad_op, 1'b1);
    check("badop_inc.pc", bif.pc, 32'h4);
    step();
    check("badop_inc.clear", bif.bad_op, 1'b0);
    check("badop_inc.pc2", bif.pc, 32'h4);

    branch("start_inc", 19'h10, 1'b0, 32'h4, 32'h4, 1);

    do_reset();
    incr(16);
    branch("prep", 19'd0, 1'b1, 32'h10, 32'h10, 0);
    bif.ir = {BrOp, 4'd3, 2'b00, 2'b00, 19'd5};
    cond_next = 1'b1;
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    step();
    check("midrst.in_decide", bif.busy, 1'b1);
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    check("midrst.pc", bif.pc, 32'h0);
    check("midrst.taken", bif.taken, 1'b0);
    check("midrst.done", bif.done, 1'b0);
    check("midrst.busy", bif.busy, 1'b0);
    step();
    check("midrst.no_done", bif.done, 1'b0);
    check("midrst.pc2", bif.pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
